// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking entrance front end.
// Optional feature macro used across this slice: PARK_LOCKOUT_EN.
package parking_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF  = 64;
  localparam int MAX_RETRIES_DEF     = 3;
  localparam int LOCKOUT_CYCLES_DEF  = 128;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COLLECT1    = 3'd1,
    ST_COLLECT2    = 3'd2,
    ST_WAIT_RESULT = 3'd3,
    ST_LOCKOUT     = 3'd4
  } entry_state_e;

  typedef logic [1:0] pass_digit_t;

endpackage

// File: rtl/parking_entry_driver_if.sv
// Signal bundle between the entrance front end (master side) and its
// environment: raw sensors, keypad, parking_system LEDs and operator status.
//
// Handshake: key_valid is a one-cycle strobe that qualifies key_code on the
// same rising edge. There is no ready/backpressure; a strobe arriving while the
// front end is not collecting digits is dropped. All other signals are levels,
// except granted/denied which are one-cycle pulses.
interface parking_entry_driver_if;
  import parking_pkg::*;

  logic        raw_entrance;
  logic        raw_exit;
  logic        key_valid;
  pass_digit_t key_code;
  logic        GREEN_LED;
  logic        RED_LED;
  logic        sensor_entrance;
  logic        sensor_exit;
  pass_digit_t password_1;
  pass_digit_t password_2;
  logic        busy;
  logic        granted;
  logic        denied;
  logic        lockout;

  modport master (
    input  raw_entrance, raw_exit, key_valid, key_code, GREEN_LED, RED_LED,
    output sensor_entrance, sensor_exit, password_1, password_2,
           busy, granted, denied, lockout
  );

  modport slave (
    output raw_entrance, raw_exit, key_valid, key_code, GREEN_LED, RED_LED,
    input  sensor_entrance, sensor_exit, password_1, password_2,
           busy, granted, denied, lockout
  );

endinterface

// File: rtl/parking_debounce.sv
// Two-flop synchroniser followed by a level filter: the filtered level only
// changes after DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module parking_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous sensor into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/parking_entry_driver.sv
// Entrance front end for parking_system: debounced sensors, two-digit keypad
// collection, verdict reading from GREEN/RED LEDs and grant/deny reporting.
// Build option PARK_LOCKOUT_EN adds a retry counter and a timed LOCKOUT state.
module parking_entry_driver
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
`ifdef PARK_LOCKOUT_EN
  parameter int MAX_RETRIES     = MAX_RETRIES_DEF,
`endif
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  parking_entry_driver_if.master bus,
  output entry_state_e           o_dbg_state
);

  // One timer serves both the collect/wait timeout and the lockout period.
  localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  logic         w_ent_filt;
  logic         w_exit_filt;
  logic         w_sensor_entrance;
  logic         w_ent_rise;
  logic         w_ent_fall;
  logic         w_timeout;
  logic         w_settled;

  entry_state_e r_state,    w_state_nxt;
  logic [TW-1:0] r_timer,   w_timer_nxt;
  pass_digit_t  r_digit1,   w_digit1_nxt;
  pass_digit_t  r_digit2,   w_digit2_nxt;
  logic         r_red_prev, w_red_prev_nxt;
  logic         r_granted,  w_granted_nxt;
  logic         r_denied,   w_denied_nxt;
  logic         r_ent_q;

`ifdef PARK_LOCKOUT_EN
  localparam int RW = $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] r_retry, w_retry_nxt;
`endif

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entrance (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.raw_entrance),
    .o_level (w_ent_filt)
  );

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (bus.raw_exit),
    .o_level (w_exit_filt)
  );

`ifdef PARK_LOCKOUT_EN
  assign w_sensor_entrance = w_ent_filt & (r_state != ST_LOCKOUT);
`else
  assign w_sensor_entrance = w_ent_filt;
`endif

  // Edges are taken on the level parking_system actually sees, so the end of
  // a lockout with the car still present counts as a fresh arrival.
  assign w_ent_rise = w_sensor_entrance & ~r_ent_q;
  assign w_ent_fall = ~w_sensor_entrance & r_ent_q;
  assign w_timeout  = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_settled  = (r_timer != '0);

  // Next-state, timer, digit latches and pulse requests.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + 1'b1;
    w_digit1_nxt   = r_digit1;
    w_digit2_nxt   = r_digit2;
    w_red_prev_nxt = 1'b0;
    w_granted_nxt  = 1'b0;
    w_denied_nxt   = 1'b0;
`ifdef PARK_LOCKOUT_EN
    w_retry_nxt    = r_retry;
`endif
    unique case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_ent_rise) w_state_nxt = ST_COLLECT1;
      end
      ST_COLLECT1, ST_COLLECT2: begin
        if (w_ent_fall) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.key_valid) begin
          if (r_state == ST_COLLECT1) begin
            w_digit1_nxt = bus.key_code;
            w_state_nxt  = ST_COLLECT2;
          end else begin
            w_digit2_nxt = bus.key_code;
            w_state_nxt  = ST_WAIT_RESULT;
          end
        end else if (w_timeout) begin
          w_denied_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_WAIT_RESULT: begin
        // The first cycle here (timer == 0) lets parking_system react to the
        // new password before its LEDs are trusted.
        if (w_ent_fall) begin
          w_state_nxt = ST_IDLE;
        end else if (w_settled && bus.GREEN_LED) begin
          w_granted_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
`ifdef PARK_LOCKOUT_EN
          w_retry_nxt   = '0;
`endif
        end else if (w_settled && bus.RED_LED && r_red_prev) begin
          w_denied_nxt = 1'b1;
`ifdef PARK_LOCKOUT_EN
          if (r_retry != RW'(MAX_RETRIES)) w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = (w_retry_nxt == RW'(MAX_RETRIES)) ? ST_LOCKOUT : ST_COLLECT1;
`else
          w_state_nxt = ST_COLLECT1;
`endif
        end else if (w_timeout) begin
          w_denied_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_red_prev_nxt = w_settled && bus.RED_LED;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
`ifdef PARK_LOCKOUT_EN
          w_retry_nxt = '0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) w_timer_nxt = '0;
    if (w_state_nxt == ST_IDLE || w_state_nxt == ST_COLLECT1 || w_state_nxt == ST_LOCKOUT) begin
      w_digit1_nxt = '0;
      w_digit2_nxt = '0;
    end
  end

  // State, timer, latches and registered pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_digit1   <= '0;
      r_digit2   <= '0;
      r_red_prev <= 1'b0;
      r_granted  <= 1'b0;
      r_denied   <= 1'b0;
      r_ent_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_digit1   <= w_digit1_nxt;
      r_digit2   <= w_digit2_nxt;
      r_red_prev <= w_red_prev_nxt;
      r_granted  <= w_granted_nxt;
      r_denied   <= w_denied_nxt;
      r_ent_q    <= w_sensor_entrance;
    end
  end

`ifdef PARK_LOCKOUT_EN
  // Failed-attempt counter, cleared on grant and at the end of lockout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_retry <= '0;
    else          r_retry <= w_retry_nxt;
  end
  assign bus.lockout = (r_state == ST_LOCKOUT);
`else
  assign bus.lockout = 1'b0;
`endif

  assign bus.sensor_entrance = w_sensor_entrance;
  assign bus.sensor_exit     = w_exit_filt;
  assign bus.password_1      = (r_state == ST_WAIT_RESULT) ? r_digit1 : '0;
  assign bus.password_2      = (r_state == ST_WAIT_RESULT) ? r_digit2 : '0;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.granted         = r_granted;
  assign bus.denied          = r_denied;
  assign o_dbg_state         = r_state;

endmodule
